// File: rtl/vram_arb_pkg.sv
// Shared types and defaults for the framebuffer port-B arbiter.
// Owner tags travel down the response pipe alongside each read.
package vram_arb_pkg;

  localparam int ADDR_W_D     = 17;
  localparam int DATA_W_D     = 32;
  localparam int RD_LAT_D     = 1;
  localparam int STARVE_MAX_D = 8;
  localparam int AUX_BURST_D  = 4;

  typedef enum logic {
    OWN_VGA,
    OWN_AUX
  } owner_t;

  typedef enum logic {
    S_VGA,
    S_AUX
  } state_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } resp_tag_t;

endpackage

// File: rtl/vram_portb_arbiter_if.sv
// Requester, response and RAM port-B signals of the arbiter.
// slave is the arbiter view, master the environment view.
interface vram_portb_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
);

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_urgent;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;

  logic              aux_req;
  logic              aux_we;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_wd;
  logic              aux_gnt;
  logic              aux_rvalid;
  logic [DATA_W-1:0] aux_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  vga_req, vga_addr, vga_urgent,
    input  aux_req, aux_we, aux_addr, aux_wd,
    input  mem_q,
    output vga_gnt, vga_rvalid, vga_rdata,
    output aux_gnt, aux_rvalid, aux_rdata,
    output mem_addr, mem_we, mem_wd
  );

  modport master (
    output vga_req, vga_addr, vga_urgent,
    output aux_req, aux_we, aux_addr, aux_wd,
    output mem_q,
    input  vga_gnt, vga_rvalid, vga_rdata,
    input  aux_gnt, aux_rvalid, aux_rdata,
    input  mem_addr, mem_we, mem_wd
  );

endinterface

// File: rtl/vram_resp_pipe.sv
// Delays read owner tags by RD_LAT cycles and steers mem_q
// to the requester that issued the read.
module vram_resp_pipe
  import vram_arb_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_D,
  parameter int DATA_W = DATA_W_D
) (
  input  logic              clk,
  input  logic              reset_n,
  input  resp_tag_t         tag_in,
  input  logic [DATA_W-1:0] mem_q,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata
);

  resp_tag_t pipe [RD_LAT];
  resp_tag_t tail;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign tail = pipe[RD_LAT-1];

  // rdata is gated so idle and reset cycles present zero
  assign vga_rvalid = tail.valid && (tail.owner == OWN_VGA);
  assign aux_rvalid = tail.valid && (tail.owner == OWN_AUX);
  assign vga_rdata  = vga_rvalid ? mem_q : '0;
  assign aux_rdata  = aux_rvalid ? mem_q : '0;

endmodule

// File: rtl/vram_portb_arbiter.sv
// Arbitrates RAM port B between VGA prefetch and the aux requester,
// with starvation forcing of aux bursts and urgent VGA preemption.
module vram_portb_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_D,
  parameter int DATA_W     = DATA_W_D,
  parameter int RD_LAT     = RD_LAT_D,
  parameter int STARVE_MAX = STARVE_MAX_D,
  parameter int AUX_BURST  = AUX_BURST_D
) (
  input logic                 clk,
  input logic                 reset_n,
  vram_portb_arbiter_if.slave bus
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam int BC_W = $clog2(AUX_BURST + 1);
  localparam logic [SC_W-1:0] S_TOP = SC_W'(STARVE_MAX);
  localparam logic [BC_W-1:0] B_TOP = BC_W'(AUX_BURST);
  localparam logic [BC_W-1:0] B_ONE = BC_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [SC_W-1:0]   starve_cnt;
  logic [SC_W-1:0]   starve_nxt;
  logic [BC_W-1:0]   burst_cnt;
  logic [BC_W-1:0]   burst_nxt;
  logic              vga_g;
  logic              aux_g;
  logic              aux_wr;
  logic              force_ok;
  logic              in_aux;
  logic [ADDR_W-1:0] addr_sel;
  resp_tag_t         tag_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_VGA;
      starve_cnt <= '0;
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      burst_cnt  <= burst_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    vga_g     = 1'b0;
    aux_g     = 1'b0;
    force_ok  = 1'b1;
    in_aux    = 1'b0;
    if (reset_n && state == S_AUX) begin
      if (bus.aux_req && !bus.vga_urgent &&
          burst_cnt < B_TOP) begin
        in_aux    = 1'b1;
        aux_g     = 1'b1;
        burst_nxt = burst_cnt + 1'b1;
      end else begin
        // leaving a burst must not immediately re-force aux
        state_nxt = S_VGA;
        burst_nxt = '0;
        force_ok  = 1'b0;
      end
    end
    if (reset_n && !in_aux) begin
      if (bus.vga_urgent && bus.vga_req) begin
        vga_g = 1'b1;
      end else if (force_ok && bus.aux_req &&
                   starve_cnt == S_TOP &&
                   !bus.vga_urgent) begin
        aux_g     = 1'b1;
        burst_nxt = B_ONE;
        state_nxt = S_AUX;
      end else if (bus.vga_req) begin
        vga_g = 1'b1;
      end else if (bus.aux_req) begin
        aux_g = 1'b1;
      end
    end
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (aux_g) begin
      starve_nxt = '0;
    end else if (bus.aux_req && starve_cnt != S_TOP) begin
      starve_nxt = starve_cnt + 1'b1;
    end
  end

  assign aux_wr   = aux_g && bus.aux_we;
  assign addr_sel = vga_g ? bus.vga_addr :
                    aux_g ? bus.aux_addr : '0;

  assign bus.vga_gnt  = vga_g;
  assign bus.aux_gnt  = aux_g;
  assign bus.mem_addr = addr_sel;
  assign bus.mem_we   = aux_wr;
  assign bus.mem_wd   = aux_wr ? bus.aux_wd : '0;

  assign tag_in = '{
    valid: vga_g || (aux_g && !bus.aux_we),
    owner: aux_g ? OWN_AUX : OWN_VGA
  };

  vram_resp_pipe #(
    .RD_LAT (RD_LAT),
    .DATA_W (DATA_W)
  ) u_resp (
    .clk        (clk),
    .reset_n    (reset_n),
    .tag_in     (tag_in),
    .mem_q      (bus.mem_q),
    .vga_rvalid (bus.vga_rvalid),
    .vga_rdata  (bus.vga_rdata),
    .aux_rvalid (bus.aux_rvalid),
    .aux_rdata  (bus.aux_rdata)
  );

endmodule

// File: tb/tb_vram_portb_arbiter.sv
// Vector table plus read scoreboard for vram_portb_arbiter,
// with a latency-modelled RAM on port B.
module tb_vram_portb_arbiter;
  import vram_arb_pkg::*;

  localparam int AW   = 17;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int SMAX = 8;
  localparam int ABUR = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  vram_portb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_portb_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .RD_LAT     (LAT),
    .STARVE_MAX (SMAX),
    .AUX_BURST  (ABUR)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // RAM model: unwritten words read back as their own address
  logic [DW-1:0] ram [int];
  logic [DW-1:0] dq [LAT];

  function automatic logic [DW-1:0] ram_rd(int a);
    return ram.exists(a) ? ram[a] : DW'(a);
  endfunction

  always @(posedge clk) begin
    dq[0] <= ram_rd(int'(bus.mem_addr));
    for (int k = 1; k < LAT; k++) dq[k] <= dq[k-1];
    if (bus.mem_we) ram[int'(bus.mem_addr)] = bus.mem_wd;
  end

  assign bus.mem_q = dq[LAT-1];

  always @(negedge clk) begin
    assert (!(bus.vga_gnt && bus.aux_gnt))
      else $error("FAIL one_gnt: both grants high");
  end

  typedef struct {
    string         nm;
    logic          vreq;
    logic          urg;
    logic [AW-1:0] vaddr;
    logic          areq;
    logic          awe;
    logic [AW-1:0] aaddr;
    logic [DW-1:0] awd;
    logic          egv;
    logic          ega;
  } vec_t;

  typedef struct {
    owner_t        own;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  vec_t          tbl [$];
  exp_t          sbq [$];
  logic [DW-1:0] exp_ram [int];
  int            n_run = 0;
  int            n_fail = 0;
  int            cyc = 0;

  function automatic logic [DW-1:0] exp_rd(int a);
    return exp_ram.exists(a) ? exp_ram[a] : DW'(a);
  endfunction

  function automatic vec_t mk(string nm, int vreq, int urg,
                              int vaddr, int areq, int awe,
                              int aaddr, logic [DW-1:0] awd,
                              int egv, int ega);
    vec_t v;
    v.nm    = nm;
    v.vreq  = (vreq != 0);
    v.urg   = (urg != 0);
    v.vaddr = AW'(vaddr);
    v.areq  = (areq != 0);
    v.awe   = (awe != 0);
    v.aaddr = AW'(aaddr);
    v.awd   = awd;
    v.egv   = (egv != 0);
    v.ega   = (ega != 0);
    return v;
  endfunction

  task automatic chk(string nm, logic [DW-1:0] act,
                     logic [DW-1:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.vga_req    = v.vreq;
    bus.vga_urgent = v.urg;
    bus.vga_addr   = v.vaddr;
    bus.aux_req    = v.areq;
    bus.aux_we     = v.awe;
    bus.aux_addr   = v.aaddr;
    bus.aux_wd     = v.awd;
  endtask

  task automatic step(vec_t v);
    logic [AW-1:0] ea;
    logic          ew;
    exp_t          e;
    @(posedge clk);
    #1;
    drive(v);
    #3;
    ew = v.ega && v.awe;
    ea = v.egv ? v.vaddr : (v.ega ? v.aaddr : '0);
    chk({v.nm, ".vga_gnt"}, DW'(bus.vga_gnt), DW'(v.egv));
    chk({v.nm, ".aux_gnt"}, DW'(bus.aux_gnt), DW'(v.ega));
    chk({v.nm, ".mem_we"}, DW'(bus.mem_we), DW'(ew));
    chk({v.nm, ".mem_addr"}, DW'(bus.mem_addr), DW'(ea));
    if (ew) chk({v.nm, ".mem_wd"}, bus.mem_wd, v.awd);
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk({v.nm, ".vga_rvalid"}, DW'(bus.vga_rvalid),
          DW'(e.own == OWN_VGA));
      chk({v.nm, ".aux_rvalid"}, DW'(bus.aux_rvalid),
          DW'(e.own == OWN_AUX));
      if (e.own == OWN_VGA) chk({v.nm, ".vga_rdata"}, bus.vga_rdata, e.data);
      else                  chk({v.nm, ".aux_rdata"}, bus.aux_rdata, e.data);
    end else begin
      chk({v.nm, ".vga_rvalid"}, DW'(bus.vga_rvalid), '0);
      chk({v.nm, ".aux_rvalid"}, DW'(bus.aux_rvalid), '0);
    end
    if (v.egv)
      sbq.push_back('{OWN_VGA, exp_rd(int'(v.vaddr)), cyc + LAT});
    else if (v.ega && !v.awe)
      sbq.push_back('{OWN_AUX, exp_rd(int'(v.aaddr)), cyc + LAT});
    if (ew) exp_ram[int'(v.aaddr)] = v.awd;
    cyc++;
  endtask

  task automatic chk_zero(string nm);
    chk({nm, ".vga_gnt"}, DW'(bus.vga_gnt), '0);
    chk({nm, ".aux_gnt"}, DW'(bus.aux_gnt), '0);
    chk({nm, ".mem_we"}, DW'(bus.mem_we), '0);
    chk({nm, ".mem_addr"}, DW'(bus.mem_addr), '0);
    chk({nm, ".vga_rvalid"}, DW'(bus.vga_rvalid), '0);
    chk({nm, ".aux_rvalid"}, DW'(bus.aux_rvalid), '0);
    chk({nm, ".vga_rdata"}, bus.vga_rdata, '0);
    chk({nm, ".aux_rdata"}, bus.aux_rdata, '0);
  endtask

  initial begin
    vec_t idle;
    int   vn;
    int   an;
    idle = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // outputs stay quiet under reset even with every request high
    drive(mk("rst", 1, 1, 'h55, 1, 1, 'h66, 32'h1234, 0, 0));
    #2;
    chk_zero("rst_hold");
    drive(idle);
    @(posedge clk);
    #2 reset_n = 1'b1;

    tbl.push_back(mk("vga0", 1, 0, 'h100, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("vga1", 1, 0, 'h101, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("vga2", 1, 0, 'h102, 0, 0, 0, 0, 1, 0));
    tbl.push_back(idle);
    tbl.push_back(idle);
    tbl.push_back(mk("awr", 0, 0, 0, 1, 1, 'h1F, 32'hDEADBEEF, 0, 1));
    tbl.push_back(mk("ard", 0, 0, 0, 1, 0, 'h1F, 0, 0, 1));
    tbl.push_back(idle);
    tbl.push_back(mk("vrd1f", 1, 0, 'h1F, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("urg_noreq", 0, 1, 'h30, 1, 0, 'h21, 0, 0, 1));
    for (int i = 0; i < 4; i++) begin
      tbl.push_back(mk("mix_v", 1, 0, 'h10, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk("mix_a", 0, 0, 0, 1, 0, 'h20, 0, 0, 1));
    end
    tbl.push_back(mk("both", 1, 0, 'h11, 1, 0, 'h22, 0, 1, 0));
    tbl.push_back(mk("aux_next", 0, 0, 0, 1, 0, 'h22, 0, 0, 1));
    tbl.push_back(idle);
    tbl.push_back(idle);

    // 8 VGA then 4 aux, repeating; ends two grants into a burst
    vn = 0;
    an = 0;
    for (int i = 0; i < 34; i++) begin
      if ((i % 12) < 8) begin
        tbl.push_back(mk("starve", 1, 0, 'h80 + vn, 1, 0, 'h200 + an, 0, 1, 0));
        vn++;
      end else begin
        tbl.push_back(mk("starve", 1, 0, 'h80 + vn, 1, 0, 'h200 + an, 0, 0, 1));
        an++;
      end
    end
    tbl.push_back(mk("urgent", 1, 1, 'h80 + vn, 1, 0, 'h200 + an, 0, 1, 0));
    vn++;
    tbl.push_back(mk("post_urg", 1, 0, 'h80 + vn, 1, 0, 'h200 + an, 0, 1, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(idle);

    foreach (tbl[i]) step(tbl[i]);

    // reset in the middle of a read stream drops in-flight reads
    step(mk("pre_a", 1, 0, 'h40, 0, 0, 0, 0, 1, 0));
    step(mk("pre_b", 1, 0, 'h41, 0, 0, 0, 0, 1, 0));
    step(mk("pre_c", 1, 0, 'h42, 0, 0, 0, 0, 1, 0));
    reset_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    sbq.delete();
    @(posedge clk);
    drive(idle);
    @(posedge clk);
    #2 reset_n = 1'b1;
    for (int i = 0; i < LAT + 2; i++) step(idle);
    step(mk("rst_after", 1, 0, 'h43, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < LAT; i++) step(idle);

    chk("sb_empty", DW'(sbq.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_portb_arbiter.md
Name: vram_portb_arbiter

Overview:
- Shares framebuffer RAM port B (second port of data_memory_dual_clock, clocked on ~clk) between two requesters.
  - VGA scanout prefetch: the default owner.
  - Auxiliary requester (sprite/blit/loader): read and write access.
- Issues at most one access per cycle, tags each read with its owner, and returns read data after the fixed RAM latency.
- Guarantees the aux requester forward progress without starving VGA when VGA is urgent.

Parameters:
- ADDR_W, 17, port B word address width (va[16:0]).
- DATA_W, 32, data word width.
- RD_LAT, 1, cycles from issue to valid mem_q (1..4).
- STARVE_MAX, 8, consecutive denied aux cycles before aux is forced.
- AUX_BURST, 4, maximum consecutive forced aux grants.

Ports:
- clk  in  1  system clock; all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- vga_req  in  1  VGA prefetch requests a read.
- vga_addr  in  ADDR_W  VGA read address.
- vga_urgent  in  1  VGA line buffer near-empty; absolute priority.
- vga_gnt  out  1  VGA request issued this cycle.
- vga_rvalid  out  1  vga_rdata valid.
- vga_rdata  out  DATA_W  VGA read data.
- aux_req  in  1  aux requests an access.
- aux_we  in  1  aux access is a write.
- aux_addr  in  ADDR_W  aux address.
- aux_wd  in  DATA_W  aux write data.
- aux_gnt  out  1  aux request issued this cycle.
- aux_rvalid  out  1  aux_rdata valid (reads only).
- aux_rdata  out  DATA_W  aux read data.
- mem_addr  out  ADDR_W  to RAM port B address.
- mem_we  out  1  to RAM port B wren.
- mem_wd  out  DATA_W  to RAM port B data.
- mem_q  in  DATA_W  from RAM port B q.

Behaviour:
- Handshake and issue timing:
  - Requester holds req and addr/data stable until it sees gnt.
  - gnt is combinational in the cycle the access issues.
  - mem_addr, mem_we and mem_wd are combinational from the granted requester.
  - With no grant: mem_we=0, mem_addr=0.
- At most one of vga_gnt and aux_gnt is high in any cycle.
- VGA requests are always reads.
- Response pipe:
  - RD_LAT-deep shift register of {valid, owner}; a slot is valid only for granted reads.
  - A read issued at cycle t produces <owner>_rvalid=1 at cycle t+RD_LAT, with <owner>_rdata=mem_q.
  - A write produces no rvalid.
  - Back-to-back reads return in issue order, one per cycle.
- starve_cnt (saturating at STARVE_MAX):
  - +1 each cycle aux_req=1 && aux_gnt=0.
  - Cleared on aux_gnt.
  - Held while aux_req=0.
- FSM states: S_VGA, S_AUX.
- S_VGA priority (highest first):
  1. vga_urgent && vga_req: grant VGA.
  2. aux_req && starve_cnt==STARVE_MAX && !vga_urgent: grant aux, load burst_cnt=1, go to S_AUX.
  3. vga_req: grant VGA.
  4. aux_req: grant aux; stay in S_VGA.
- S_AUX:
  - Grant aux while aux_req && !vga_urgent && burst_cnt<AUX_BURST; burst_cnt+1 per grant.
  - Otherwise return to S_VGA in the same cycle and apply the S_VGA rules for that cycle's grant; starve_cnt is not re-forced.
- vga_urgent=1 with vga_req=0: no grant to VGA; aux may be granted under rule 4.
- Reset, reset_n=0 (asynchronous):
  - FSM to S_VGA; starve_cnt=0, burst_cnt=0; response pipe cleared.
  - All gnt, rvalid and mem_we outputs 0; rdata=0; mem_addr=0.
  - In-flight reads at reset are dropped: no rvalid after reset_n rises.
- Widths: counters are clog2(STARVE_MAX+1) and clog2(AUX_BURST+1) bits; no wrap beyond saturation.

Decomposition:
- Package vram_arb_pkg:
  - typedef enum owner_t {OWN_VGA, OWN_AUX}.
  - typedef enum state_t {S_VGA, S_AUX}.
  - typedef struct resp_tag_t {valid, owner}.
  - Default parameter constants.
- One sub-module: vram_resp_pipe.
  - Parameterised by RD_LAT.
  - Shifts resp_tag_t and demuxes mem_q into the vga/aux rvalid and rdata outputs.
- Arbitration FSM and counters stay in the top module.

Test Plan:
- Reset: assert reset_n=0 mid-read with RD_LAT=2 -> all outputs 0 immediately; no vga_rvalid after release.
- VGA only: vga_req=1 with addr 0x100, 0x101, 0x102 on consecutive cycles, mem_q model = addr -> vga_rvalid on cycles t+1..t+3 with rdata 0x100..0x102.
- Starvation: vga_req and aux_req held high with aux_we=0 -> 8 VGA grants, then 4 aux grants (S_AUX), then VGA resumes; pattern repeats.
- Urgent preempt: in S_AUX at burst_cnt=2, raise vga_urgent with vga_req=1 -> vga_gnt that same cycle, FSM returns to S_VGA, aux_gnt=0.
- Aux write then read: aux_we=1, addr 0x1F, wd 0xDEADBEEF with VGA idle -> mem_we=1 for one cycle and no aux_rvalid; then an aux read of 0x1F -> aux_rvalid after RD_LAT with rdata 0xDEADBEEF.
- Mixed ordering: alternate VGA read 0x10 and aux read 0x20, RD_LAT=3 -> responses route to the correct owner in issue order; at most one gnt per cycle, checked by assertion.
